// File: rtl/kernel_pkg.sv
// Shared types and defaults for the ping-pong kernel coefficient store.
package kernel_pkg;

    typedef enum logic {
        LOADING = 1'b0,
        FULL    = 1'b1
    } shadow_state_t;

    localparam int KERNEL_WIDTH = 16;
    localparam int KERNEL_KSIZE = 3;

    function automatic int kernel_addr_w(input int ksize);
        return (ksize * ksize > 1) ? $clog2(ksize * ksize) : 1;
    endfunction

endpackage

// File: rtl/kernel_bank.sv
// One DEPTH x WIDTH coefficient bank: single synchronous write port, NUM_RD combinational reads.
// Latency: write lands at the clock edge, reads are 0-cycle; no backpressure, out-of-range reads give 0.
module kernel_bank
    import kernel_pkg::*;
#(
    parameter int WIDTH  = KERNEL_WIDTH,
    parameter int DEPTH  = KERNEL_KSIZE * KERNEL_KSIZE,
    parameter int NUM_RD = 3,
    parameter int ADDR_W = kernel_addr_w(KERNEL_KSIZE)
)(
    input  logic                           clk,
    input  logic                           i_arst_n,
    input  logic                           i_we,
    input  logic [ADDR_W-1:0]              i_waddr,
    input  logic [WIDTH-1:0]               i_wdata,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  i_rd_addr,
    output logic [NUM_RD-1:0][WIDTH-1:0]   o_rd_data
);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;

    always_ff @(posedge clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_mem <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_we && (i_waddr == ADDR_W'(i))) begin
                    r_mem[i] <= i_wdata;
                end
            end
        end
    end

    // Address decode by match keeps out-of-range indices at 0 without an OOB access.
    always_comb begin
        o_rd_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (i_rd_addr[p] == ADDR_W'(j)) begin
                    o_rd_data[p] = r_mem[j];
                end
            end
        end
    end

endmodule

// File: rtl/kernel_bank_reg.sv
// Ping-pong kernel store: streaming loader fills the shadow bank, MAC reads the active bank.
// Latency: reads 0-cycle, swap ack combinational (flip at the ack edge); load_ready low while shadow is FULL.
module kernel_bank_reg
    import kernel_pkg::*;
#(
    parameter  int WIDTH  = KERNEL_WIDTH,
    parameter  int KSIZE  = KERNEL_KSIZE,
    parameter  int NUM_RD = 3,
    localparam int DEPTH  = KSIZE * KSIZE,
    localparam int ADDR_W = kernel_addr_w(KSIZE)
)(
    input  logic                           clk,
    input  logic                           arst_n_in,
    input  logic                           load_valid,
    output logic                           load_ready,
    input  logic [WIDTH-1:0]               load_data,
    input  logic                           load_clear,
    input  logic                           swap_req,
    output logic                           swap_ack,
    output logic                           active_valid,
    output logic                           shadow_full,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
    output logic [NUM_RD-1:0][WIDTH-1:0]   rd_data
);

    shadow_state_t                 r_state;
    logic [ADDR_W-1:0]             r_wr_ptr;
    logic                          r_active_sel;
    logic                          r_active_valid;

    logic                          w_xfer;
    logic                          w_swap;
    logic                          w_we0;
    logic                          w_we1;
    logic [NUM_RD-1:0][WIDTH-1:0]  w_rd_b0;
    logic [NUM_RD-1:0][WIDTH-1:0]  w_rd_b1;

    assign load_ready   = (r_state == LOADING);
    assign shadow_full  = (r_state == FULL);
    assign active_valid = r_active_valid;

    // Swap is decided on registered state, so a last-word transfer cannot ack in the same cycle.
    assign w_swap   = swap_req && (r_state == FULL);
    assign swap_ack = w_swap;
    assign w_xfer   = load_valid && load_ready && !load_clear;

    // The shadow bank is the one not selected as active.
    assign w_we0 = w_xfer &&  r_active_sel;
    assign w_we1 = w_xfer && !r_active_sel;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_state        <= LOADING;
            r_wr_ptr       <= '0;
            r_active_sel   <= 1'b0;
            r_active_valid <= 1'b0;
        end else if (w_swap) begin
            r_active_sel   <= !r_active_sel;
            r_active_valid <= 1'b1;
            r_state        <= LOADING;
            r_wr_ptr       <= '0;
        end else if (load_clear) begin
            r_state  <= LOADING;
            r_wr_ptr <= '0;
        end else if (w_xfer) begin
            if (r_wr_ptr == ADDR_W'(DEPTH - 1)) begin
                r_wr_ptr <= '0;
                r_state  <= FULL;
            end else begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
        end
    end

    kernel_bank #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .ADDR_W (ADDR_W)
    ) u_bank0 (
        .clk       (clk),
        .i_arst_n  (arst_n_in),
        .i_we      (w_we0),
        .i_waddr   (r_wr_ptr),
        .i_wdata   (load_data),
        .i_rd_addr (rd_addr),
        .o_rd_data (w_rd_b0)
    );

    kernel_bank #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .ADDR_W (ADDR_W)
    ) u_bank1 (
        .clk       (clk),
        .i_arst_n  (arst_n_in),
        .i_we      (w_we1),
        .i_waddr   (r_wr_ptr),
        .i_wdata   (load_data),
        .i_rd_addr (rd_addr),
        .o_rd_data (w_rd_b1)
    );

    assign rd_data = r_active_sel ? w_rd_b1 : w_rd_b0;

endmodule

// File: doc/kernel_bank_reg.md
Name: kernel_bank_reg

Overview:
- Double-buffered (ping-pong) kernel coefficient store for the convolution datapath.
- A streaming loader fills the shadow bank word by word while the MAC array reads the active bank through several parallel combinational read ports.
- A swap handshake flips banks in one cycle, so the next kernel loads while the current one is in use.
- Generalises the fixed 9-entry, single-read-port kernel register in width, kernel size and read-port count, and adds load sequencing and bank switching.

Parameters:
- WIDTH, 16, bits per kernel coefficient
- KSIZE, 3, kernel edge; DEPTH = KSIZE*KSIZE entries per bank
- NUM_RD, 3, number of independent combinational read ports on the active bank
- ADDR_W, $clog2(DEPTH), derived, not overridden

Ports:
- clk  in  1  clock; single clock domain
- arst_n_in  in  1  asynchronous, active-low reset
- load_valid  in  1  load_data is valid this cycle
- load_ready  out  1  shadow bank accepts a word; transfer = load_valid & load_ready
- load_data  in  WIDTH  coefficient, written in raster order, index 0 first
- load_clear  in  1  abort the current load; shadow pointer returns to 0
- swap_req  in  1  level request to make the shadow bank active; held until ack
- swap_ack  out  1  one-cycle pulse; banks flipped at this clock edge
- active_valid  out  1  active bank holds a complete kernel
- shadow_full  out  1  shadow bank holds DEPTH words
- rd_addr  in  NUM_RD x ADDR_W  per-port read index
- rd_data  out  NUM_RD x WIDTH  per-port coefficient from the active bank, 0-cycle latency

Behaviour:
- Reset (async assert, sync-safe release):
  - both banks are zeroed; active_sel=0; wr_ptr=0; shadow state is LOADING.
  - load_ready=1, swap_ack=0, active_valid=0, shadow_full=0, rd_data=0.
- Shadow state machine (per shadow bank, registered):
  - LOADING: load_ready=1. Each transfer writes bank[~active_sel][wr_ptr] and increments wr_ptr. A transfer at wr_ptr==DEPTH-1 sets wr_ptr=0 and the state to FULL.
  - FULL: load_ready=0; shadow_full=1; load_valid is ignored.
- Swap:
  - Sampled when swap_req=1 and the state is FULL: active_sel toggles, the state returns to LOADING, wr_ptr=0, active_valid is set to 1, and swap_ack pulses high for exactly one cycle.
  - swap_req while LOADING causes no action and no ack; the request stays pending until the shadow bank is full.
  - Last-word transfer and swap_req in the same cycle: the swap decision uses the registered state, so the ack occurs on the next cycle at the earliest (minimum 1 cycle after the last word).
  - After a swap, the new shadow bank still holds the old kernel. Its contents are overwritten by the next load; they are not cleared.
- load_clear:
  - Highest priority over load_valid in the same cycle: wr_ptr=0, state LOADING, no write occurs.
  - Has no effect on the active bank, active_valid or active_sel.
  - If asserted while FULL, it discards the full shadow kernel.
  - load_clear together with a swap-eligible swap_req: the swap wins, and the clear is redundant because the pointer resets anyway.
- Reads:
  - rd_data[i] = active bank[rd_addr[i]], purely combinational.
  - rd_addr[i] >= DEPTH returns 0.
  - Ports are independent; identical addresses on several ports are legal.
  - The active bank is never written, so reads are stable during loading.
- Reads in the swap cycle: rd_data switches to the new bank immediately after the ack edge.
- Reset mid-load or mid-swap: everything returns to its reset values; a partial kernel is lost.

Decomposition:
- Shared package kernel_pkg:
  - shadow_state_t enum {LOADING, FULL}.
  - Default WIDTH/KSIZE constants.
  - Function kernel_addr_w(ksize).
- Sub-module kernel_bank, instantiated twice:
  - DEPTH x WIDTH register array.
  - One synchronous write port (we, waddr, wdata).
  - NUM_RD combinational read ports with out-of-range returning 0.
  - Async active-low clear.
- kernel_bank_reg holds the FSM, wr_ptr, active_sel, swap logic and the output mux between the two banks.

Test Plan:
- Reset, then load 9 words 0x0001..0x0009 back-to-back with swap_req low:
  - load_ready drops the cycle after the 9th transfer and shadow_full=1.
  - active_valid stays 0 and all rd_data=0.
- Continuing, raise swap_req:
  - swap_ack pulses once, active_valid=1.
  - rd_addr={0,4,8} reads {0x0001,0x0005,0x0009}.
  - rd_addr=9 or 15 reads 0.
- Load a second kernel 0x0100..0x0108 while reads continue on the active bank:
  - rd_data stays at the first kernel throughout.
  - After the swap, rd_addr=4 reads 0x0104.
- Hold swap_req high from the start of a load:
  - No ack during words 1..9.
  - Ack exactly 1 cycle after the 9th transfer; no second ack while swap_req stays high and the shadow is LOADING.
- Load 5 words, pulse load_clear with load_valid=1, then load 9 words 0x0A00..0x0A08 and swap:
  - rd_addr=0 reads 0x0A00, so the clear-cycle word was not written.
  - The active kernel is unchanged until the swap.
- Assert arst_n_in low after a swap while 3 words are loaded:
  - All outputs return to their reset values, rd_data=0, load_ready=1.
  - A full reload plus swap works normally afterwards.
